// File: rtl/nbody_pair_scheduler_if.sv
// Handshake bundle between the pair scheduler and the force / update datapaths.
// The master side issues pairs and update slots; the slave side returns ready.
interface nbody_pair_scheduler_if #(
  parameter int BODY_ADDR_WIDTH = 9
);
  logic                       pair_valid;
  logic                       pair_ready;
  logic [BODY_ADDR_WIDTH-1:0] pair_i;
  logic [BODY_ADDR_WIDTH-1:0] pair_j;
  logic                       pair_first;
  logic                       pair_last;
  logic                       upd_valid;
  logic                       upd_ready;
  logic [BODY_ADDR_WIDTH-1:0] upd_idx;

  modport master (
    output pair_valid, pair_i, pair_j, pair_first, pair_last, upd_valid, upd_idx,
    input  pair_ready, upd_ready
  );

  modport slave (
    input  pair_valid, pair_i, pair_j, pair_first, pair_last, upd_valid, upd_idx,
    output pair_ready, upd_ready
  );
endinterface

// File: rtl/nbody_pair_scheduler.sv
// Sequences one n-body run: (i,j) force pairs, pipeline drain, per-body update slots, per step.
// Define NBODY_SCHED_SYMMETRIC_EN to issue only j>i pairs (datapath applies equal and opposite force).
module nbody_pair_scheduler #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int LATENCY         = 122,
  parameter int UPD_LATENCY     = 11,
  parameter int STEP_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic [BODY_ADDR_WIDTH:0]  n_bodies,
  input  logic [STEP_WIDTH-1:0]     steps,
  nbody_pair_scheduler_if.master    sched,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_WIDTH-1:0]     step_count
);
  localparam int AW       = BODY_ADDR_WIDTH;
  localparam int NW       = BODY_ADDR_WIDTH + 1;
  localparam int WAIT_MAX = (LATENCY > UPD_LATENCY) ? LATENCY : UPD_LATENCY;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] DRAIN_LAST  = WW'(LATENCY - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(UPD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PAIRS  = 3'd1,
    DRAIN  = 3'd2,
    UPDATE = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [AW-1:0]         i_r, j_r, u_r, i_nxt_s, j_nxt_s, u_nxt_s;
  logic [NW-1:0]         n_r, n_nxt_s, n_m1_s, n_m2_s, fn_m1_s, fn_m2_s;
  logic [STEP_WIDTH-1:0] s_r, s_nxt_s, step_r, step_nxt_s;
  logic [WW-1:0]         wait_r, wait_nxt_s;
  logic                  pair_valid_r, pair_first_r, pair_last_r, upd_valid_r, busy_r, done_r;
  logic                  first_nxt_s, last_nxt_s, pair_fire_s, upd_fire_s, final_pair_s, abort_s;

  assign pair_fire_s = pair_valid_r && sched.pair_ready;
  assign upd_fire_s  = upd_valid_r && sched.upd_ready;
  assign n_m1_s      = n_r - NW'(1);
  assign n_m2_s      = n_r - NW'(2);
  assign abort_s     = !go && (state_r inside {PAIRS, DRAIN, UPDATE, SETTLE});
`ifdef NBODY_SCHED_SYMMETRIC_EN
  assign final_pair_s = pair_last_r && ({1'b0, i_r} == n_m2_s);
`else
  assign final_pair_s = pair_last_r && ({1'b0, i_r} == n_m1_s);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and counter updates; abort overrides every busy state
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    j_nxt_s     = j_r;
    u_nxt_s     = u_r;
    n_nxt_s     = n_r;
    s_nxt_s     = s_r;
    step_nxt_s  = step_r;
    wait_nxt_s  = wait_r;
    if (abort_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (go) begin
            step_nxt_s = STEP_WIDTH'(0);
            if ((n_bodies >= NW'(2)) && (steps != STEP_WIDTH'(0))) begin
              state_nxt_s = PAIRS;
              n_nxt_s     = n_bodies;
              s_nxt_s     = steps;
              i_nxt_s     = AW'(0);
              j_nxt_s     = AW'(1);
            end else begin
              state_nxt_s = DONE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PAIRS: begin
          if (!pair_fire_s) begin
            state_nxt_s = PAIRS;
          end else if (final_pair_s) begin
            state_nxt_s = DRAIN;
            wait_nxt_s  = WW'(0);
          end else if (pair_last_r) begin
            i_nxt_s = i_r + AW'(1);
`ifdef NBODY_SCHED_SYMMETRIC_EN
            j_nxt_s = i_r + AW'(2);
`else
            j_nxt_s = AW'(0);
`endif
          end else begin
`ifdef NBODY_SCHED_SYMMETRIC_EN
            j_nxt_s = j_r + AW'(1);
`else
            // step over the self-pair
            if ((j_r + AW'(1)) == i_r) begin
              j_nxt_s = j_r + AW'(2);
            end else begin
              j_nxt_s = j_r + AW'(1);
            end
`endif
          end
        end
        DRAIN: begin
          if (wait_r == DRAIN_LAST) begin
            state_nxt_s = UPDATE;
            u_nxt_s     = AW'(0);
          end else begin
            wait_nxt_s = wait_r + WW'(1);
          end
        end
        UPDATE: begin
          if (upd_fire_s && ({1'b0, u_r} == n_m1_s)) begin
            state_nxt_s = SETTLE;
            step_nxt_s  = step_r + STEP_WIDTH'(1);
            wait_nxt_s  = WW'(0);
          end else if (upd_fire_s) begin
            u_nxt_s = u_r + AW'(1);
          end else begin
            state_nxt_s = UPDATE;
          end
        end
        SETTLE: begin
          if ((wait_r == SETTLE_LAST) && (step_r == s_r)) begin
            state_nxt_s = DONE;
          end else if (wait_r == SETTLE_LAST) begin
            state_nxt_s = PAIRS;
            i_nxt_s     = AW'(0);
            j_nxt_s     = AW'(1);
          end else begin
            wait_nxt_s = wait_r + WW'(1);
          end
        end
        DONE: begin
          if (!go) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Accumulator clear/commit flags for the pair about to be presented
  always_comb begin
    fn_m1_s = n_nxt_s - NW'(1);
    fn_m2_s = n_nxt_s - NW'(2);
`ifdef NBODY_SCHED_SYMMETRIC_EN
    first_nxt_s = ({1'b0, j_nxt_s} == ({1'b0, i_nxt_s} + NW'(1)));
    last_nxt_s  = ({1'b0, j_nxt_s} == fn_m1_s);
`else
    first_nxt_s = (j_nxt_s == AW'(0)) || ((i_nxt_s == AW'(0)) && (j_nxt_s == AW'(1)));
    if ({1'b0, i_nxt_s} == fn_m1_s) begin
      last_nxt_s = ({1'b0, j_nxt_s} == fn_m2_s);
    end else begin
      last_nxt_s = ({1'b0, j_nxt_s} == fn_m1_s);
    end
`endif
  end

  // Counters, latched run parameters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r          <= AW'(0);
      j_r          <= AW'(0);
      u_r          <= AW'(0);
      n_r          <= NW'(0);
      s_r          <= STEP_WIDTH'(0);
      step_r       <= STEP_WIDTH'(0);
      wait_r       <= WW'(0);
      pair_valid_r <= 1'b0;
      pair_first_r <= 1'b0;
      pair_last_r  <= 1'b0;
      upd_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      i_r          <= i_nxt_s;
      j_r          <= j_nxt_s;
      u_r          <= u_nxt_s;
      n_r          <= n_nxt_s;
      s_r          <= s_nxt_s;
      step_r       <= step_nxt_s;
      wait_r       <= wait_nxt_s;
      pair_valid_r <= (state_nxt_s == PAIRS);
      pair_first_r <= (state_nxt_s == PAIRS) && first_nxt_s;
      pair_last_r  <= (state_nxt_s == PAIRS) && last_nxt_s;
      upd_valid_r  <= (state_nxt_s == UPDATE);
      busy_r       <= (state_nxt_s inside {PAIRS, DRAIN, UPDATE, SETTLE});
      done_r       <= (state_nxt_s == DONE);
    end
  end

  assign sched.pair_valid = pair_valid_r;
  assign sched.pair_i     = i_r;
  assign sched.pair_j     = j_r;
  assign sched.pair_first = pair_first_r;
  assign sched.pair_last  = pair_last_r;
  assign sched.upd_valid  = upd_valid_r;
  assign sched.upd_idx    = u_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign step_count       = step_r;
endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Directed self-checking bench for nbody_pair_scheduler (LATENCY=122, UPD_LATENCY=11).
// Follows NBODY_SCHED_SYMMETRIC_EN so the expected pair order matches the build.
`timescale 1ns/1ps
module tb_nbody_pair_scheduler;
  localparam int AW = 9;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, go;
  logic [AW:0]   n_bodies;
  logic [SW-1:0] steps;
  logic          busy, done;
  logic [SW-1:0] step_count;
  int            tests = 0;
  int            fails = 0;

`ifdef NBODY_SCHED_SYMMETRIC_EN
  localparam int NP3 = 3;
  localparam int NP25 = 1800;
  localparam bit SYM = 1'b1;
  int exp_i [6] = '{0, 0, 1, 0, 0, 0};
  int exp_j [6] = '{1, 2, 2, 0, 0, 0};
  int exp_f [6] = '{1, 0, 1, 0, 0, 0};
  int exp_l [6] = '{0, 1, 1, 0, 0, 0};
`else
  localparam int NP3 = 6;
  localparam int NP25 = 3600;
  localparam bit SYM = 1'b0;
  int exp_i [6] = '{0, 0, 1, 1, 2, 2};
  int exp_j [6] = '{1, 2, 0, 2, 0, 1};
  int exp_f [6] = '{1, 0, 1, 0, 1, 0};
  int exp_l [6] = '{0, 1, 0, 1, 0, 1};
`endif

  nbody_pair_scheduler_if #(.BODY_ADDR_WIDTH(AW)) sched ();

  nbody_pair_scheduler #(
    .BODY_ADDR_WIDTH(AW), .LATENCY(122), .UPD_LATENCY(11), .STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .n_bodies(n_bodies), .steps(steps),
    .sched(sched), .busy(busy), .done(done), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pair ordering, written as plain index iteration
  task automatic model_next(input int n, inout int i, inout int j);
    if (SYM) begin
      j++;
      if (j >= n) begin i++; j = i + 1; end
      if (j >= n) begin i = 0; j = 1; end
    end else begin
      j++;
      if (j == i) j++;
      if (j >= n) begin i++; j = (i == 0) ? 1 : 0; end
      if (i >= n) begin i = 0; j = 1; end
    end
  endtask

  function automatic bit model_first(input int n, input int i, input int j);
    if (SYM) return j == i + 1;
    return (j == 0) || (i == 0 && j == 1);
  endfunction

  function automatic bit model_last(input int n, input int i, input int j);
    if (SYM) return j == n - 1;
    return (i == n - 1) ? (j == n - 2) : (j == n - 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, stray, k, cyc, mi, mj, pairs, upds, order_err, step_err, done_rises, prev_step, after;
    bit stalled, prev_done, tmo;
    logic [31:0] held;

    rst = 1'b1; go = 1'b0; n_bodies = '0; steps = '0;
    sched.pair_ready = 1'b0; sched.upd_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_pair_valid", sched.pair_valid, 0);
    chk("rst_upd_valid", sched.upd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_pair_ij", {sched.pair_i, sched.pair_j}, 0);

    // N=3, S=1, always ready
    n_bodies = 10'd3; steps = 16'd1; sched.pair_ready = 1'b1; sched.upd_ready = 1'b1; go = 1'b1;
    tick();
    chk("run_busy", busy, 1);
    for (int p = 0; p < NP3; p++) begin
      chk($sformatf("p%0d_valid", p), sched.pair_valid, 1);
      chk($sformatf("p%0d_i", p), sched.pair_i, exp_i[p]);
      chk($sformatf("p%0d_j", p), sched.pair_j, exp_j[p]);
      chk($sformatf("p%0d_first", p), sched.pair_first, exp_f[p]);
      chk($sformatf("p%0d_last", p), sched.pair_last, exp_l[p]);
      tick();
    end
    cnt = 0; stray = 0;
    while (!sched.upd_valid && cnt < 300) begin
      if (sched.pair_valid) stray++;
      cnt++;
      tick();
    end
    chk("drain_cycles", cnt, 122);
    chk("drain_no_pair", stray, 0);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("upd%0d_valid", u), sched.upd_valid, 1);
      chk($sformatf("upd%0d_idx", u), sched.upd_idx, u);
      tick();
    end
    cnt = 0; stray = 0;
    while (!done && cnt < 100) begin
      if (!busy || sched.upd_valid) stray++;
      cnt++;
      tick();
    end
    chk("settle_cycles", cnt, 11);
    chk("settle_quiet", stray, 0);
    chk("done_set", done, 1);
    chk("done_busy", busy, 0);
    chk("done_step_count", step_count, 1);
    go = 1'b0;
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);

    // pair_ready pattern 1,0,0,1 repeating
    go = 1'b1;
    tick();
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < NP3 && cyc < 100) begin
      sched.pair_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (stalled)
        chk($sformatf("stall_hold_c%0d", cyc),
            {sched.pair_valid, sched.pair_first, sched.pair_last, 2'b0, sched.pair_i, sched.pair_j}, held);
      if (sched.pair_valid && sched.pair_ready) begin
        chk($sformatf("stall_pair%0d", k), {sched.pair_i, sched.pair_j},
            {exp_i[k][AW-1:0], exp_j[k][AW-1:0]});
        k++;
      end
      held = {sched.pair_valid, sched.pair_first, sched.pair_last, 2'b0, sched.pair_i, sched.pair_j};
      stalled = sched.pair_valid && !sched.pair_ready;
      tick();
      cyc++;
    end
    chk("stall_count", k, NP3);
    chk("stall_no_extra", sched.pair_valid, 0);
    sched.pair_ready = 1'b1;
    go = 1'b0;
    tick();

    // N=25, S=6 full run against the reference ordering
    n_bodies = 10'd25; steps = 16'd6; go = 1'b1;
    tick();
    mi = 0; mj = 1; pairs = 0; upds = 0; order_err = 0; step_err = 0;
    done_rises = 0; prev_step = 0; prev_done = 1'b0; after = 0; cnt = 0;
    while (cnt < 12000 && after < 20) begin
      if (sched.pair_valid) begin
        if (sched.pair_i !== mi[AW-1:0] || sched.pair_j !== mj[AW-1:0] ||
            sched.pair_first !== model_first(25, mi, mj) || sched.pair_last !== model_last(25, mi, mj))
          order_err++;
        pairs++;
        model_next(25, mi, mj);
      end
      if (sched.upd_valid) begin
        if (sched.upd_idx !== AW'(upds % 25)) order_err++;
        upds++;
      end
      if (int'(step_count) != prev_step) begin
        if (int'(step_count) != prev_step + 1) step_err++;
        prev_step = int'(step_count);
      end
      if (done && !prev_done) done_rises++;
      prev_done = done;
      if (done) after++;
      cnt++;
      tick();
    end
    chk("n25_pairs", pairs, NP25);
    chk("n25_upds", upds, 150);
    chk("n25_order", order_err, 0);
    chk("n25_step_seq", step_err, 0);
    chk("n25_step_count", step_count, 6);
    chk("n25_done_once", done_rises, 1);
    chk("n25_done", done, 1);
    go = 1'b0;
    tick();

    // Abort in DRAIN of step 2
    n_bodies = 10'd3; steps = 16'd2; go = 1'b1;
    cnt = 0;
    while (step_count != 16'd1 && cnt < 1000) begin cnt++; tick(); end
    while (!sched.pair_valid && cnt < 1000) begin cnt++; tick(); end
    while (sched.pair_valid && cnt < 1000) begin cnt++; tick(); end
    tmo = (cnt >= 1000);
    chk("abort_reach_drain", tmo, 0);
    repeat (5) tick();
    chk("abort_pre_busy", busy, 1);
    go = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_valids", {sched.pair_valid, sched.upd_valid}, 0);
    chk("abort_step_count", step_count, 1);
    chk("abort_done", done, 0);
    go = 1'b1;
    tick();
    chk("restart_valid", sched.pair_valid, 1);
    chk("restart_pair", {sched.pair_i, sched.pair_j}, {9'd0, 9'd1});
    chk("restart_step_count", step_count, 0);
    go = 1'b0;
    tick();

    // Degenerate programming
    n_bodies = 10'd1; steps = 16'd4; go = 1'b1;
    tick();
    chk("n1_done", done, 1);
    chk("n1_busy", busy, 0);
    chk("n1_valids", {sched.pair_valid, sched.upd_valid}, 0);
    chk("n1_step_count", step_count, 0);
    go = 1'b0;
    tick();
    chk("n1_done_clear", done, 0);
    n_bodies = 10'd3; steps = 16'd0; go = 1'b1;
    tick();
    chk("s0_done", done, 1);
    chk("s0_valids", {busy, sched.pair_valid, sched.upd_valid}, 0);
    go = 1'b0;
    tick();

    // Reset mid-PAIRS with go still high
    steps = 16'd1; sched.pair_ready = 1'b0; go = 1'b1;
    tick();
    chk("mid_valid", sched.pair_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", sched.pair_valid, 0);
    chk("mid_rst_flags", {busy, done, sched.pair_first, sched.pair_last}, 0);
    chk("mid_rst_ij", {sched.pair_i, sched.pair_j}, 0);
    chk("mid_rst_step", step_count, 0);
    rst = 1'b0; go = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
